// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths, MEM-stage FSM encoding and ALU control codes.
package cpu_pkg;

    localparam int CPU_DATA_W      = 64;
    localparam int CPU_REG_W       = 5;
    localparam int ADDR_ALIGN_BITS = 3;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } mem_state_e;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLL  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9
    } alu_op_e;

    function automatic logic is_dword_aligned(input logic [ADDR_ALIGN_BITS-1:0] low_bits);
        return (low_bits == '0);
    endfunction

endpackage

// File: rtl/mem_stage.sv
// Pipeline MEM stage: issues aligned loads/stores to data memory, waits for ack,
// and emits a one-cycle write-back pulse; misaligned ops are reported without a bus request.
module mem_stage
    import cpu_pkg::*;
#(
    parameter int DATA_W = CPU_DATA_W,
    parameter int REG_W  = CPU_REG_W
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [DATA_W-1:0] i_alu_result,
    input  logic [DATA_W-1:0] i_store_data,
    input  logic              i_mem_read,
    input  logic              i_mem_write,
    input  logic              i_reg_write,
    input  logic [REG_W-1:0]  i_rd,
    input  logic              i_flush,
    output logic              o_mem_req,
    output logic              o_mem_we,
    output logic [DATA_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_wdata,
    input  logic              i_mem_ack,
    input  logic [DATA_W-1:0] i_mem_rdata,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_wb_data,
    output logic [REG_W-1:0]  o_rd,
    output logic              o_reg_write,
    output logic              o_misaligned
);

    mem_state_e        state_q, state_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [DATA_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              valid_q, valid_d;
    logic              misaligned_q, misaligned_d;
    logic              reg_write_q, reg_write_d;
    logic [DATA_W-1:0] wb_data_q, wb_data_d;
    logic [REG_W-1:0]  rd_q, rd_d;
    // Write-back fields of the outstanding memory op, held off the outputs until ack
    logic [REG_W-1:0]  pend_rd_q, pend_rd_d;
    logic              pend_rw_q, pend_rw_d;
    logic              pend_load_q, pend_load_d;
    logic              flush_pend_q, flush_pend_d;

    logic xfer;
    logic mem_op;

    assign xfer   = i_valid && (state_q == ST_IDLE);
    assign mem_op = i_mem_read || i_mem_write;

    always_comb begin
        state_d      = state_q;
        mem_req_d    = mem_req_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        valid_d      = 1'b0;
        misaligned_d = 1'b0;
        reg_write_d  = 1'b0;
        wb_data_d    = wb_data_q;
        rd_d         = rd_q;
        pend_rd_d    = pend_rd_q;
        pend_rw_d    = pend_rw_q;
        pend_load_d  = pend_load_q;
        flush_pend_d = flush_pend_q;

        case (state_q)
            ST_IDLE: begin
                if (xfer && !i_flush) begin
                    if (!mem_op) begin
                        valid_d     = 1'b1;
                        wb_data_d   = i_alu_result;
                        rd_d        = i_rd;
                        reg_write_d = i_reg_write && (i_rd != '0);
                    end else if (!is_dword_aligned(i_alu_result[ADDR_ALIGN_BITS-1:0])) begin
                        valid_d      = 1'b1;
                        misaligned_d = 1'b1;
                        wb_data_d    = i_alu_result;
                        rd_d         = i_rd;
                    end else begin
                        // Read+write together is a store
                        state_d      = ST_BUSY;
                        mem_req_d    = 1'b1;
                        mem_we_d     = i_mem_write;
                        mem_addr_d   = i_alu_result;
                        mem_wdata_d  = i_store_data;
                        pend_rd_d    = i_rd;
                        pend_rw_d    = i_reg_write && !i_mem_write && (i_rd != '0);
                        pend_load_d  = !i_mem_write;
                        flush_pend_d = 1'b0;
                    end
                end
            end
            ST_BUSY: begin
                if (i_mem_ack) begin
                    state_d      = ST_IDLE;
                    mem_req_d    = 1'b0;
                    mem_we_d     = 1'b0;
                    flush_pend_d = 1'b0;
                    if (!(flush_pend_q || i_flush)) begin
                        valid_d     = 1'b1;
                        rd_d        = pend_rd_q;
                        reg_write_d = pend_rw_q;
                        if (pend_load_q) begin
                            wb_data_d = i_mem_rdata;
                        end
                    end
                end else if (i_flush) begin
                    // No bus abort: keep the request up, just drop its result
                    flush_pend_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= ST_IDLE;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            valid_q      <= 1'b0;
            misaligned_q <= 1'b0;
            reg_write_q  <= 1'b0;
            wb_data_q    <= '0;
            rd_q         <= '0;
            pend_rd_q    <= '0;
            pend_rw_q    <= 1'b0;
            pend_load_q  <= 1'b0;
            flush_pend_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            valid_q      <= valid_d;
            misaligned_q <= misaligned_d;
            reg_write_q  <= reg_write_d;
            wb_data_q    <= wb_data_d;
            rd_q         <= rd_d;
            pend_rd_q    <= pend_rd_d;
            pend_rw_q    <= pend_rw_d;
            pend_load_q  <= pend_load_d;
            flush_pend_q <= flush_pend_d;
        end
    end

    assign o_ready      = (state_q == ST_IDLE);
    assign o_mem_req    = mem_req_q;
    assign o_mem_we     = mem_we_q;
    assign o_mem_addr   = mem_addr_q;
    assign o_mem_wdata  = mem_wdata_q;
    assign o_valid      = valid_q;
    assign o_misaligned = misaligned_q;
    assign o_reg_write  = reg_write_q;
    assign o_wb_data    = wb_data_q;
    assign o_rd         = rd_q;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed scenarios plus randomized single-instruction
// transactions checked against a transaction-level reference model.
module tb_mem_stage;

    localparam int DW = 64;
    localparam int RW = 5;

    logic          i_clk = 1'b0;
    logic          i_rst_n;
    logic          i_valid;
    logic          o_ready;
    logic [DW-1:0] i_alu_result;
    logic [DW-1:0] i_store_data;
    logic          i_mem_read, i_mem_write, i_reg_write;
    logic [RW-1:0] i_rd;
    logic          i_flush;
    logic          o_mem_req, o_mem_we;
    logic [DW-1:0] o_mem_addr, o_mem_wdata;
    logic          i_mem_ack;
    logic [DW-1:0] i_mem_rdata;
    logic          o_valid;
    logic [DW-1:0] o_wb_data;
    logic [RW-1:0] o_rd;
    logic          o_reg_write, o_misaligned;

    int vecs = 0;
    int errs = 0;

    mem_stage #(.DATA_W(DW), .REG_W(RW)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .o_ready(o_ready),
        .i_alu_result(i_alu_result), .i_store_data(i_store_data),
        .i_mem_read(i_mem_read), .i_mem_write(i_mem_write), .i_reg_write(i_reg_write),
        .i_rd(i_rd), .i_flush(i_flush), .o_mem_req(o_mem_req), .o_mem_we(o_mem_we),
        .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata), .i_mem_ack(i_mem_ack),
        .i_mem_rdata(i_mem_rdata), .o_valid(o_valid), .o_wb_data(o_wb_data), .o_rd(o_rd),
        .o_reg_write(o_reg_write), .o_misaligned(o_misaligned)
    );

    always #5 i_clk = ~i_clk;

    // Inputs change and outputs are sampled 1 time unit after each rising edge
    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic issue(input logic [DW-1:0] alu, input logic [DW-1:0] sd, input logic rd_en,
                         input logic wr_en, input logic rw, input logic [RW-1:0] rd, input logic fl);
        i_valid = 1'b1; i_alu_result = alu; i_store_data = sd;
        i_mem_read = rd_en; i_mem_write = wr_en; i_reg_write = rw; i_rd = rd; i_flush = fl;
        tick();
        i_valid = 1'b0; i_flush = 1'b0; i_mem_read = 1'b0; i_mem_write = 1'b0; i_reg_write = 1'b0;
    endtask

    task automatic test_reset();
        i_rst_n = 1'b0; i_valid = 1'b0; i_alu_result = '0; i_store_data = '0;
        i_mem_read = 1'b0; i_mem_write = 1'b0; i_reg_write = 1'b0; i_rd = '0;
        i_flush = 1'b0; i_mem_ack = 1'b0; i_mem_rdata = '0;
        #12;
        vecs++;
        if ({o_mem_req, o_mem_we, o_valid, o_misaligned, o_reg_write} !== 5'b0 ||
            o_wb_data !== '0 || o_rd !== '0 || o_mem_addr !== '0 || o_mem_wdata !== '0) begin
            errs++;
            $display("FAIL reset_outputs: req=%0b we=%0b v=%0b mis=%0b rw=%0b wb=%h rd=%0d addr=%h wd=%h want all 0",
                     o_mem_req, o_mem_we, o_valid, o_misaligned, o_reg_write, o_wb_data, o_rd, o_mem_addr, o_mem_wdata);
        end
        i_rst_n = 1'b1;
        tick();
        vecs++;
        if (o_ready !== 1'b1 || o_valid !== 1'b0) begin
            errs++; $display("FAIL reset_release: ready=%0b valid=%0b want 1/0", o_ready, o_valid);
        end
    endtask

    task automatic test_alu_op();
        issue(64'h2A, 64'h0, 1'b0, 1'b0, 1'b1, 5'd5, 1'b0);
        vecs++;
        if (o_valid !== 1'b1 || o_wb_data !== 64'h2A || o_rd !== 5'd5 || o_reg_write !== 1'b1 ||
            o_misaligned !== 1'b0 || o_mem_req !== 1'b0 || o_ready !== 1'b1) begin
            errs++;
            $display("FAIL alu_op: v=%0b wb=%h rd=%0d rw=%0b mis=%0b req=%0b rdy=%0b want 1/2a/5/1/0/0/1",
                     o_valid, o_wb_data, o_rd, o_reg_write, o_misaligned, o_mem_req, o_ready);
        end
        issue(64'h77, 64'h0, 1'b0, 1'b0, 1'b1, 5'd0, 1'b0);
        vecs++;
        if (o_valid !== 1'b1 || o_reg_write !== 1'b0 || o_wb_data !== 64'h77) begin
            errs++; $display("FAIL alu_rd0: v=%0b rw=%0b wb=%h want 1/0/77", o_valid, o_reg_write, o_wb_data);
        end
        tick();
        vecs++;
        if (o_valid !== 1'b0 || o_wb_data !== 64'h77 || o_rd !== 5'd0) begin
            errs++; $display("FAIL alu_pulse: v=%0b wb=%h rd=%0d want 0/77/0 held", o_valid, o_wb_data, o_rd);
        end
    endtask

    task automatic test_load();
        issue(64'h100, 64'h0, 1'b1, 1'b0, 1'b1, 5'd9, 1'b0);
        for (int c = 0; c < 3; c++) begin
            vecs++;
            if (o_mem_req !== 1'b1 || o_ready !== 1'b0 || o_mem_addr !== 64'h100 ||
                o_mem_we !== 1'b0 || o_valid !== 1'b0) begin
                errs++;
                $display("FAIL load_req c%0d: req=%0b rdy=%0b addr=%h we=%0b v=%0b want 1/0/100/0/0",
                         c, o_mem_req, o_ready, o_mem_addr, o_mem_we, o_valid);
            end
            if (c == 2) begin i_mem_ack = 1'b1; i_mem_rdata = 64'hDEAD_BEEF; end
            tick();
        end
        i_mem_ack = 1'b0; i_mem_rdata = '0;
        vecs++;
        if (o_valid !== 1'b1 || o_wb_data !== 64'hDEAD_BEEF || o_rd !== 5'd9 || o_reg_write !== 1'b1 ||
            o_mem_req !== 1'b0 || o_ready !== 1'b1) begin
            errs++;
            $display("FAIL load_done: v=%0b wb=%h rd=%0d rw=%0b req=%0b rdy=%0b want 1/deadbeef/9/1/0/1",
                     o_valid, o_wb_data, o_rd, o_reg_write, o_mem_req, o_ready);
        end
        tick();
    endtask

    task automatic test_store();
        issue(64'h108, 64'h55, 1'b0, 1'b1, 1'b1, 5'd3, 1'b0);
        vecs++;
        if (o_mem_req !== 1'b1 || o_mem_we !== 1'b1 || o_mem_wdata !== 64'h55 || o_mem_addr !== 64'h108) begin
            errs++;
            $display("FAIL store_req: req=%0b we=%0b wd=%h addr=%h want 1/1/55/108", o_mem_req, o_mem_we, o_mem_wdata, o_mem_addr);
        end
        i_mem_ack = 1'b1;
        tick();
        i_mem_ack = 1'b0;
        vecs++;
        if (o_valid !== 1'b1 || o_reg_write !== 1'b0 || o_misaligned !== 1'b0 || o_mem_req !== 1'b0) begin
            errs++;
            $display("FAIL store_done: v=%0b rw=%0b mis=%0b req=%0b want 1/0/0/0", o_valid, o_reg_write, o_misaligned, o_mem_req);
        end
        tick();
    endtask

    task automatic test_misaligned();
        issue(64'h103, 64'h0, 1'b1, 1'b0, 1'b1, 5'd7, 1'b0);
        vecs++;
        if (o_valid !== 1'b1 || o_misaligned !== 1'b1 || o_reg_write !== 1'b0 || o_mem_req !== 1'b0 || o_ready !== 1'b1) begin
            errs++;
            $display("FAIL misaligned: v=%0b mis=%0b rw=%0b req=%0b rdy=%0b want 1/1/0/0/1",
                     o_valid, o_misaligned, o_reg_write, o_mem_req, o_ready);
        end
        tick();
        vecs++;
        if (o_misaligned !== 1'b0 || o_valid !== 1'b0) begin
            errs++; $display("FAIL misaligned_pulse: mis=%0b v=%0b want 0/0", o_misaligned, o_valid);
        end
    endtask

    task automatic test_flush_idle();
        issue(64'h55, 64'h0, 1'b0, 1'b0, 1'b1, 5'd4, 1'b1);
        vecs++;
        if (o_valid !== 1'b0) begin errs++; $display("FAIL flush_idle_alu: v=%0b want 0", o_valid); end
        issue(64'h200, 64'h0, 1'b1, 1'b0, 1'b1, 5'd4, 1'b1);
        vecs++;
        if (o_mem_req !== 1'b0 || o_ready !== 1'b1 || o_valid !== 1'b0) begin
            errs++; $display("FAIL flush_idle_load: req=%0b rdy=%0b v=%0b want 0/1/0", o_mem_req, o_ready, o_valid);
        end
    endtask

    task automatic test_flush_busy();
        issue(64'h200, 64'h0, 1'b1, 1'b0, 1'b1, 5'd6, 1'b0);
        i_flush = 1'b1;
        tick();
        i_flush = 1'b0;
        for (int c = 0; c < 2; c++) begin
            vecs++;
            if (o_mem_req !== 1'b1 || o_mem_addr !== 64'h200 || o_valid !== 1'b0) begin
                errs++; $display("FAIL flush_busy_hold c%0d: req=%0b addr=%h v=%0b want 1/200/0", c, o_mem_req, o_mem_addr, o_valid);
            end
            if (c == 1) begin i_mem_ack = 1'b1; i_mem_rdata = 64'h1234; end
            tick();
        end
        i_mem_ack = 1'b0;
        vecs++;
        if (o_valid !== 1'b0 || o_mem_req !== 1'b0 || o_ready !== 1'b1) begin
            errs++; $display("FAIL flush_busy_done: v=%0b req=%0b rdy=%0b want 0/0/1", o_valid, o_mem_req, o_ready);
        end
        issue(64'h99, 64'h0, 1'b0, 1'b0, 1'b1, 5'd2, 1'b0);
        vecs++;
        if (o_valid !== 1'b1 || o_wb_data !== 64'h99 || o_rd !== 5'd2) begin
            errs++; $display("FAIL flush_busy_next: v=%0b wb=%h rd=%0d want 1/99/2", o_valid, o_wb_data, o_rd);
        end
        tick();
    endtask

    task automatic test_flush_ack();
        issue(64'h300, 64'h0, 1'b1, 1'b0, 1'b1, 5'd8, 1'b0);
        i_mem_ack = 1'b1; i_mem_rdata = 64'hABCD; i_flush = 1'b1;
        tick();
        i_mem_ack = 1'b0; i_flush = 1'b0;
        vecs++;
        if (o_valid !== 1'b0 || o_mem_req !== 1'b0 || o_ready !== 1'b1) begin
            errs++; $display("FAIL flush_ack: v=%0b req=%0b rdy=%0b want 0/0/1", o_valid, o_mem_req, o_ready);
        end
    endtask

    task automatic test_reset_busy();
        issue(64'h400, 64'h0, 1'b1, 1'b0, 1'b1, 5'd1, 1'b0);
        tick();
        i_rst_n = 1'b0;
        #1;
        vecs++;
        if (o_mem_req !== 1'b0 || o_ready !== 1'b1 || o_valid !== 1'b0 || o_mem_addr !== '0) begin
            errs++; $display("FAIL reset_busy: req=%0b rdy=%0b v=%0b addr=%h want 0/1/0/0", o_mem_req, o_ready, o_valid, o_mem_addr);
        end
        #2 i_rst_n = 1'b1;
        tick();
        vecs++;
        if (o_ready !== 1'b1) begin errs++; $display("FAIL reset_busy_ready: rdy=%0b want 1", o_ready); end
        issue(64'h11, 64'h0, 1'b0, 1'b0, 1'b1, 5'd12, 1'b0);
        vecs++;
        if (o_valid !== 1'b1 || o_wb_data !== 64'h11 || o_rd !== 5'd12 || o_reg_write !== 1'b1) begin
            errs++; $display("FAIL reset_busy_next: v=%0b wb=%h rd=%0d rw=%0b want 1/11/12/1", o_valid, o_wb_data, o_rd, o_reg_write);
        end
        tick();
    endtask

    // Reference: each instruction is classified by the stage rules and its expected
    // bus activity and write-back outcome are computed before it is applied.
    task automatic test_random();
        for (int n = 0; n < 60; n++) begin
            int            kind  = int'($urandom_range(0, 3));
            int            fmode = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
            int            lat   = int'($urandom_range(0, 3));
            logic [DW-1:0] alu   = {$urandom, $urandom};
            logic [DW-1:0] sd    = {$urandom, $urandom};
            logic [DW-1:0] rdat  = {$urandom, $urandom};
            logic [RW-1:0] rd    = ($urandom_range(0, 4) == 0) ? '0 : RW'($urandom);
            logic          rw    = 1'($urandom);
            logic          rd_en = (kind == 1) || (kind == 3);
            logic          wr_en = (kind == 2) || (kind == 3);
            logic          memop = rd_en || wr_en;
            logic          dropped;
            if (memop && $urandom_range(0, 3) != 0) alu = alu & ~64'h7;
            issue(alu, sd, rd_en, wr_en, rw, rd, fmode == 1);
            if (fmode == 1) begin
                vecs++;
                if (o_valid !== 1'b0 || o_mem_req !== 1'b0) begin
                    errs++; $display("FAIL rnd%0d flushed_xfer: v=%0b req=%0b want 0/0", n, o_valid, o_mem_req);
                end
            end else if (!memop || (alu % 8) != 0) begin
                vecs++;
                if (o_valid !== 1'b1 || o_misaligned !== memop || o_mem_req !== 1'b0 || o_rd !== rd ||
                    o_reg_write !== (!memop && rw && rd != 0) || o_wb_data !== alu) begin
                    errs++;
                    $display("FAIL rnd%0d direct: v=%0b mis=%0b req=%0b rd=%0d rw=%0b wb=%h want 1/%0b/0/%0d/%0b/%h",
                             n, o_valid, o_misaligned, o_mem_req, o_rd, o_reg_write, o_wb_data,
                             memop, rd, (!memop && rw && rd != 0), alu);
                end
            end else begin
                for (int c = 0; c <= lat; c++) begin
                    vecs++;
                    if (o_mem_req !== 1'b1 || o_ready !== 1'b0 || o_mem_addr !== alu || o_mem_we !== wr_en ||
                        o_valid !== 1'b0 || (wr_en && o_mem_wdata !== sd)) begin
                        errs++;
                        $display("FAIL rnd%0d busy c%0d: req=%0b rdy=%0b addr=%h we=%0b wd=%h v=%0b want 1/0/%h/%0b/%h/0",
                                 n, c, o_mem_req, o_ready, o_mem_addr, o_mem_we, o_mem_wdata, o_valid, alu, wr_en, sd);
                    end
                    i_flush = (fmode == 2 && c == 0) || (fmode == 3 && c == lat);
                    if (c == lat) begin i_mem_ack = 1'b1; i_mem_rdata = rdat; end
                    tick();
                    i_flush = 1'b0; i_mem_ack = 1'b0; i_mem_rdata = {$urandom, $urandom};
                end
                dropped = (fmode != 0);
                vecs++;
                if (o_valid !== !dropped || o_mem_req !== 1'b0 || o_ready !== 1'b1 || o_misaligned !== 1'b0 ||
                    (!dropped && (o_rd !== rd || o_reg_write !== (!wr_en && rw && rd != 0) ||
                                  (!wr_en && o_wb_data !== rdat)))) begin
                    errs++;
                    $display("FAIL rnd%0d done: v=%0b req=%0b rdy=%0b rd=%0d rw=%0b wb=%h want v=%0b rd=%0d rw=%0b wb=%h",
                             n, o_valid, o_mem_req, o_ready, o_rd, o_reg_write, o_wb_data,
                             !dropped, rd, (!wr_en && rw && rd != 0), rdat);
                end
            end
            tick();
            vecs++;
            if (o_valid !== 1'b0 || o_mem_req !== 1'b0 || o_ready !== 1'b1) begin
                errs++; $display("FAIL rnd%0d settle: v=%0b req=%0b rdy=%0b want 0/0/1", n, o_valid, o_mem_req, o_ready);
            end
        end
    endtask

    initial begin
        test_reset();
        test_alu_op();
        test_load();
        test_store();
        test_misaligned();
        test_flush_idle();
        test_flush_busy();
        test_flush_ack();
        test_reset_busy();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
